// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared types for the up/down sweep controller: FSM state codes, which are also
// the values reported on the phase output.
package updown_sweep_ctrl_pkg;

  localparam int unsigned PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_UP       = 3'd1,
    ST_HOLD_TOP = 3'd2,
    ST_DOWN     = 3'd3,
    ST_HOLD_BOT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/updown_cnt.sv
// Synchronous up/down counter with a synchronous zero-load. It does no range
// checking; the controlling FSM keeps the value inside 0..limit.
module updown_cnt #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load0,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load0) begin
      count_d = '0;
    end else if (enable) begin
      count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer that drives an up/down counter through N triangular sweeps
// (0 -> limit, dwell, limit -> 0, dwell) and reports busy/done/phase.
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned HOLD_W  = 4,
  parameter int unsigned SWEEP_W = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   limit,
  input  logic [HOLD_W-1:0]  hold,
  input  logic [SWEEP_W-1:0] sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic [PHASE_W-1:0] phase
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [HOLD_W-1:0]  dwell_q, dwell_d;
  logic [SWEEP_W-1:0] rem_q, rem_d;
  logic               busy_q, done_q;
  logic [PHASE_W-1:0] phase_q;

  logic               start_ok;
  logic               cnt_load0, cnt_en, cnt_up;
  logic [WIDTH-1:0]   cnt_val;

  // A start is only honoured from IDLE with a non-zero limit; abort wins a tie.
  assign start_ok = (state_q == ST_IDLE) && start && !abort && (limit != '0);

  updown_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clock  (clock),
    .clear  (clear),
    .load0  (cnt_load0),
    .enable (cnt_en),
    .up     (cnt_up),
    .count  (cnt_val)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      hold_q  <= '0;
      dwell_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      hold_q  <= hold_d;
      dwell_q <= dwell_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      phase_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    hold_d  = hold_q;
    dwell_d = dwell_q;
    rem_d   = rem_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_d = ST_UP;
            limit_d = limit;
            hold_d  = hold;
            rem_d   = (sweeps == '0) ? SWEEP_W'(1) : sweeps;
          end
        end
        ST_UP: begin
          // This edge lifts the counter onto limit.
          if (cnt_val == (limit_q - WIDTH'(1))) begin
            if (hold_q != '0) begin
              state_d = ST_HOLD_TOP;
              dwell_d = hold_q;
            end else begin
              state_d = ST_DOWN;
            end
          end
        end
        ST_HOLD_TOP: begin
          if (dwell_q == HOLD_W'(1)) begin
            state_d = ST_DOWN;
          end else begin
            dwell_d = dwell_q - HOLD_W'(1);
          end
        end
        ST_DOWN: begin
          // This edge brings the counter back to zero: one sweep finished.
          if (cnt_val == WIDTH'(1)) begin
            rem_d = rem_q - SWEEP_W'(1);
            if (rem_q == SWEEP_W'(1)) begin
              state_d = ST_DONE;
            end else if (hold_q != '0) begin
              state_d = ST_HOLD_BOT;
              dwell_d = hold_q;
            end else begin
              state_d = ST_UP;
            end
          end
        end
        ST_HOLD_BOT: begin
          if (dwell_q == HOLD_W'(1)) begin
            state_d = ST_UP;
          end else begin
            dwell_d = dwell_q - HOLD_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Counter controls; abort freezes the count at whatever value it holds.
  always_comb begin
    cnt_load0 = start_ok;
    cnt_en    = 1'b0;
    cnt_up    = 1'b0;
    if (!abort) begin
      case (state_q)
        ST_UP:   begin cnt_en = 1'b1; cnt_up = 1'b1; end
        ST_DOWN: begin cnt_en = 1'b1; cnt_up = 1'b0; end
        default: begin cnt_en = 1'b0; cnt_up = 1'b0; end
      endcase
    end
  end

  assign count = cnt_val;
  assign busy  = busy_q;
  assign done  = done_q;
  assign phase = phase_q;

endmodule
